// File: rtl/mux_32x8.sv
// mux_32x8: 32-to-8 serializer on clk_4f, MSB byte first, with a one-word skid buffer.
// Define MUX32X8_IDLE_EN to drive IDLE_BYTE on data_out_32x8 whenever no valid byte is sent.
module mux_32x8 #(
    parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_in_32x8,
    input  logic        valid_in_32x8,
    output logic        ready_in_32x8,
    output logic [7:0]  data_out_32x8,
    output logic        valid_out_32x8,
    output logic [1:0]  selector_out_32x8
);

`ifdef MUX32X8_IDLE_EN
    localparam logic [7:0] IdleData = IDLE_BYTE;
`else
    // Idle pattern disabled; the mask keeps IDLE_BYTE referenced in this build.
    localparam logic [7:0] IdleData = IDLE_BYTE & 8'h00;
`endif

    // StSend doubles as the hold-register valid flag.
    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] skid_q, skid_d;
    logic        skid_v_q, skid_v_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic [1:0]  sel_out_q, sel_out_d;
    logic        accept;
    logic [7:0]  cur_byte;

    assign ready_in_32x8 = !skid_v_q;
    assign accept        = valid_in_32x8 && ready_in_32x8;

    always_comb begin
        unique case (sel_q)
            2'd0: cur_byte = hold_q[31:24];
            2'd1: cur_byte = hold_q[23:16];
            2'd2: cur_byte = hold_q[15:8];
            2'd3: cur_byte = hold_q[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        skid_d      = skid_q;
        skid_v_d    = skid_v_q;
        sel_d       = sel_q;
        data_out_d  = IdleData;
        valid_out_d = 1'b0;
        sel_out_d   = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_d  = data_in_32x8;
                    sel_d   = 2'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                data_out_d  = cur_byte;
                sel_out_d   = sel_q;
                valid_out_d = 1'b1;
                sel_d       = sel_q + 2'd1;
                if (sel_q == 2'd3) begin
                    // Word boundary: skid has priority, then a same-edge accept.
                    if (skid_v_q) begin
                        hold_d   = skid_q;
                        skid_v_d = 1'b0;
                    end else if (accept) begin
                        hold_d = data_in_32x8;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    skid_d   = data_in_32x8;
                    skid_v_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            hold_q      <= 32'd0;
            skid_q      <= 32'd0;
            skid_v_q    <= 1'b0;
            sel_q       <= 2'd0;
            data_out_q  <= IdleData;
            valid_out_q <= 1'b0;
            sel_out_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            skid_q      <= skid_d;
            skid_v_q    <= skid_v_d;
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sel_out_q   <= sel_out_d;
        end
    end

    assign data_out_32x8     = data_out_q;
    assign valid_out_32x8    = valid_out_q;
    assign selector_out_32x8 = sel_out_q;

endmodule

// File: tb/tb_mux_32x8.sv
// Self-checking bench for mux_32x8: vector table, byte-queue reference model and
// a reassembling loopback receiver keyed on selector_out.
module tb_mux_32x8;

`ifdef MUX32X8_IDLE_EN
    localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
    localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  sel_out;

    int checks = 0;
    int failures = 0;

    logic [9:0]  exp_q[$];   // {selector, byte} still owed on the output
    logic [31:0] word_q[$];  // accepted words awaiting reassembly
    logic [31:0] asm_w;

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic        vo;
        logic [1:0]  so;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[20];

    mux_32x8 dut (
        .clk_4f            (clk),
        .reset             (rst),
        .data_in_32x8      (data_in),
        .valid_in_32x8     (valid_in),
        .ready_in_32x8     (ready_in),
        .data_out_32x8     (data_out),
        .valid_out_32x8    (valid_out),
        .selector_out_32x8 (sel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic vin, input logic [31:0] din, input logic rdy,
                                input logic vo, input logic [1:0] so, input logic [7:0] dout);
        vec_t v;
        v.vin = vin; v.din = din; v.rdy = rdy; v.vo = vo; v.so = so;
        v.dout = vo ? dout : IDLE_EXP;
        return v;
    endfunction

    // One clock of model-checked traffic; called at posedge+1.
    task automatic step(input logic vin, input logic [31:0] din, output logic acc);
        logic       m_ready;
        logic [9:0] e;
        logic       ev;
        logic [1:0] es;
        logic [7:0] ed;
        // Words in flight = bytes owed rounded up to words; at most two fit.
        m_ready = (((exp_q.size() + 3) / 4) < 2);
        valid_in = vin;
        data_in  = din;
        check("ready_in", ready_in, m_ready);
        acc = vin && m_ready;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ev = 1'b1; es = e[9:8]; ed = e[7:0];
        end else begin
            ev = 1'b0; es = 2'd0; ed = IDLE_EXP;
        end
        check("valid_out", valid_out, ev);
        check("selector_out", sel_out, es);
        check("data_out", data_out, ed);
        if (valid_out) begin
            asm_w[8*(3-int'(sel_out)) +: 8] = data_out;
            if (sel_out == 2'd3) begin
                if (word_q.size() == 0) check("loopback_extra", asm_w, 32'hxxxxxxxx);
                else check("loopback_word", asm_w, word_q.pop_front());
            end
        end
        if (acc) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back({2'(i), 8'(din >> (24 - 8 * i))});
            word_q.push_back(din);
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] sw[3];
        int          idx, cyc, run, best_run, acc_cyc, sent;

        vecs[0]  = mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 8'h00);
        vecs[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 8'hDE);
        vecs[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd1, 8'hAD);
        vecs[3]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd2, 8'hBE);
        vecs[4]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 8'hEF);
        vecs[5]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00);
        vecs[6]  = mk(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 2'd0, 8'h00);
        vecs[7]  = mk(1'b1, 32'h01020304, 1'b1, 1'b1, 2'd0, 8'hA1);
        vecs[8]  = mk(1'b1, 32'h05060708, 1'b0, 1'b1, 2'd1, 8'hB2);
        vecs[9]  = mk(1'b1, 32'h05060708, 1'b0, 1'b1, 2'd2, 8'hC3);
        vecs[10] = mk(1'b1, 32'h05060708, 1'b0, 1'b1, 2'd3, 8'hD4);
        vecs[11] = mk(1'b1, 32'h05060708, 1'b1, 1'b1, 2'd0, 8'h01);
        vecs[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 2'd1, 8'h02);
        vecs[13] = mk(1'b0, 32'h0,        1'b0, 1'b1, 2'd2, 8'h03);
        vecs[14] = mk(1'b0, 32'h0,        1'b0, 1'b1, 2'd3, 8'h04);
        vecs[15] = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 8'h05);
        vecs[16] = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd1, 8'h06);
        vecs[17] = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd2, 8'h07);
        vecs[18] = mk(1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 8'h08);
        vecs[19] = mk(1'b0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00);
        asm_w = 32'd0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_selector", sel_out, 2'd0);
        check("rst_data_out", data_out, IDLE_EXP);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 32'h0, acc);

        // Single word followed by a skid-fill sequence.
        foreach (vecs[i]) begin
            valid_in = vecs[i].vin;
            data_in  = vecs[i].din;
            check($sformatf("vec%0d_ready", i), ready_in, vecs[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), valid_out, vecs[i].vo);
            check($sformatf("vec%0d_sel", i), sel_out, vecs[i].so);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].dout);
        end

        // Streaming with valid held high: 12 contiguous bytes.
        sw[0] = 32'h01020304; sw[1] = 32'h05060708; sw[2] = 32'h090A0B0C;
        idx = 0; run = 0; best_run = 0; acc_cyc = -1;
        for (cyc = 0; cyc < 20; cyc++) begin
            step(idx < 3, (idx < 3) ? sw[idx] : 32'h0, acc);
            if (acc) begin
                idx++;
                if (idx == 3) acc_cyc = cyc;
            end
            run = valid_out ? run + 1 : 0;
            if (run > best_run) best_run = run;
        end
        check("stream_accepts", idx, 3);
        check("stream_third_accept_cycle", acc_cyc, 5);
        check("stream_contiguous_bytes", best_run, 12);

        // Reset in the middle of a word; nothing of it may survive.
        step(1'b1, 32'hCAFEF00D, acc);
        step(1'b0, 32'h0, acc);
        step(1'b0, 32'h0, acc);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_selector", sel_out, 2'd0);
        check("midrst_data_out", data_out, IDLE_EXP);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        word_q.delete();
        step(1'b1, 32'h11223344, acc);
        repeat (6) step(1'b0, 32'h0, acc);
        check("midrst_drained", word_q.size(), 0);

        // Random traffic through the model and the loopback receiver.
        sent = 0;
        for (cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
            step($urandom_range(0, 9) < 6, $urandom, acc);
            if (acc) sent++;
        end
        repeat (10) step(1'b0, 32'h0, acc);
        check("random_sent", sent, 100);
        check("loopback_pending", word_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_32x8.md
Name: mux_32x8

Overview:
- 32-bit to 8-bit serializer on the clk_4f domain. Transmit-side counterpart of the team's 8-to-32 byte deserializer.
- Accepts one 32-bit word per handshake and emits it as four consecutive bytes, MSB byte first.
- Drives a 2-bit byte selector alongside each byte so the downstream deserializer places every byte into the matching lane.
- Includes a one-word skid buffer so a continuously valid upstream sees no bubbles on the byte stream.

Parameters:
- IDLE_BYTE, 8'hBC, byte driven on data_out_32x8 while no valid byte is sent (used only when MUX32X8_IDLE_EN is defined).

Ports:
- clk_4f  input  1  byte-rate clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in_32x8  input  32  word to serialize.
- valid_in_32x8  input  1  data_in_32x8 is valid.
- ready_in_32x8  output  1  block can accept a word this cycle.
- data_out_32x8  output  8  serialized byte (registered).
- valid_out_32x8  output  1  data_out_32x8 holds a valid byte (registered).
- selector_out_32x8  output  2  lane index of the current byte: 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0] (registered).

Behaviour:
- Reset (asynchronous, high): all outputs go to 0 immediately, except data_out_32x8 = IDLE_BYTE when the option is enabled. Hold register, skid register and both valid flags clear; byte counter = 0; FSM = IDLE. A partially sent word is discarded, with no completion after reset deasserts.
- Storage: hold register plus hold_v flag; skid register plus skid_v flag; 2-bit byte counter sel.
- Handshake:
  - ready_in_32x8 = !skid_v (combinational from state only, never from valid_in).
  - A word is accepted on an edge where valid_in_32x8 = 1 and ready_in_32x8 = 1.
  - An accepted word goes into hold if, before that edge, hold is empty or hold is emitting its last byte (sel = 3) with skid empty. Otherwise it goes into skid.
- FSM states:
  - IDLE (hold_v = 0): valid_out = 0, selector = 0. An accept loads hold, sets hold_v, sel = 0, and moves to SEND.
  - SEND (hold_v = 1): every edge registers data_out = hold byte[sel] (MSB first), selector_out = sel, valid_out = 1, then sel increments with 2-bit wrap.
- End of a word (edge that emits sel = 3):
  - If skid_v: move skid into hold and clear skid_v.
  - Else if a word is accepted on the same edge: load it into hold.
  - Otherwise clear hold_v and return to IDLE.
  - In every case sel wraps to 0.
- Latency: a word accepted at edge k produces its bytes on the outputs after edges k+1 through k+4.
- Back-to-back throughput: one word per 4 cycles; valid_out stays high continuously with no gap between words.
- Simultaneous skid refill: if skid is full at a word boundary and a new word is also offered, the offer is not accepted, because ready_in_32x8 is 0 that cycle.
- Output when not valid: valid_out = 0 and selector_out = 0. data_out = 8'h00 without the option, IDLE_BYTE with it.
- valid_in_32x8 deasserting mid-word has no effect on the word already in hold.

Optional Feature:
- Macro MUX32X8_IDLE_EN.
- Defined: data_out_32x8 = IDLE_BYTE whenever valid_out_32x8 = 0, including during and after reset, so the link carries a known idle pattern.
- Undefined: data_out_32x8 = 8'h00 whenever valid_out_32x8 = 0.
- Valid-byte behaviour and timing are identical in both builds.

Test Plan:
- Reset check: assert reset mid-clock → all outputs read 0 (or 8'hBC with the option) before the next edge. Release reset → valid_out stays 0 and ready_in = 1.
- Single word: accept 32'hDEADBEEF at edge k → bytes DE, AD, BE, EF with selector 0, 1, 2, 3 after edges k+1 to k+4 → then valid_out = 0 and the block is back in IDLE.
- Streaming: hold valid_in high with words 32'h01020304, 32'h05060708, 32'h090A0B0C → 12 contiguous valid bytes 01 to 0C, no bubble, and ready_in never drops below the rate needed for one accept per 4 cycles.
- Skid fill: accept word A, then keep offering B and C → B lands in skid, ready_in = 0 until A's last byte, C is accepted only after B moves to hold, and byte order is A, B, C.
- Reset mid-word: after byte 2 of 32'hCAFEF00D, assert reset for 1 cycle, then send 32'h11223344 → output is exactly 11, 22, 33, 44, with no residual CA/FE/F0/0D bytes.
- Loopback: connect the serializer to the team's 8-to-32 deserializer via data_out, valid_out and selector_out, and send 100 random words → every reassembled word equals its input.
